reg_file_dump: RTL and testbench

REG_FILE_DUMP -- requirements
Module: reg_file_dump

---
 rtl/reg_file_dump.sv | 96 +++++++++
 tb/tb_reg_file_dump.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump.sv
// reg_file_dump: streams registers 0..31 out over a valid/ready port, reading one word per beat.
// Define DUMP_CHECKSUM_EN to append a 33rd beat carrying the XOR of all captured words.
module reg_file_dump (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic [4:0]  A_out,
  input  logic [31:0] RD_in,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_last,
  output logic        dump_sum,
  output logic        busy,
  output logic        done
);
`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, SUM, DONE} state_t;
  localparam state_t AFTER_LAST = SUM;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
  localparam state_t AFTER_LAST = DONE;
`endif
  state_t state, nxt;
  logic [4:0] idx, a_hold;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] sum;
  assign dump_valid = state == SEND || state == SUM;
`else
  assign dump_valid = state == SEND;
  assign dump_sum = 1'b0;
`endif
  assign A_out = state == READ ? idx : a_hold;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? READ : IDLE;
      READ: nxt = SEND;
      SEND: nxt = !dump_ready ? SEND : idx != 5'd31 ? READ : AFTER_LAST;
`ifdef DUMP_CHECKSUM_EN
      SUM: nxt = dump_ready ? DONE : SUM;
`endif
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      a_hold <= '0;
      dump_addr <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum <= '0;
      dump_sum <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        idx <= '0;
`ifdef DUMP_CHECKSUM_EN
        sum <= '0;
`endif
      end
      if (state == READ) begin
        a_hold <= idx;
        dump_addr <= idx;
        dump_data <= RD_in;
`ifdef DUMP_CHECKSUM_EN
        dump_last <= 1'b0;
        dump_sum <= 1'b0;
        sum <= sum ^ RD_in;
`else
        dump_last <= idx == 5'd31;
`endif
      end
      if (state == SEND && dump_ready) begin
        if (idx != 5'd31) idx <= idx + 5'd1;
`ifdef DUMP_CHECKSUM_EN
        else begin
          // sum already includes word 31, captured in the preceding READ
          dump_addr <= 5'h1F;
          dump_data <= sum;
          dump_last <= 1'b1;
          dump_sum <= 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_reg_file_dump.sv
// tb_reg_file_dump: directed stimulus with a beat-sequence scoreboard model checked every cycle.
module tb_reg_file_dump;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  A_out;
  logic [31:0] RD_in;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        dump_sum;
  logic        busy;
  logic        done;
  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;
`ifdef DUMP_CHECKSUM_EN
  localparam int TOTAL = 33;
  localparam logic LAST31 = 1'b0;
`else
  localparam int TOTAL = 32;
  localparam logic LAST31 = 1'b1;
`endif
  // model state: idle / in a dump (n beats accepted) / done cycle pending
  logic m_idle = 1'b1;
  logic m_done = 1'b0;
  int n = 0;
  logic stall_prev = 1'b0;
  logic [4:0] p_addr;
  logic [31:0] p_data;
  logic p_last, p_sum;

  reg_file_dump dut (
    .CLK(CLK), .RST(RST), .start(start), .A_out(A_out), .RD_in(RD_in),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_last(dump_last), .dump_sum(dump_sum),
    .busy(busy), .done(done)
  );

  assign RD_in = rf[A_out];
  always #5 CLK = ~CLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] xsum();
    logic [31:0] s = '0;
    for (int i = 0; i < 32; i++) s ^= rf[i];
    return s;
  endfunction

  task automatic monitor();
    logic fin = 1'b0;
    logic [4:0] ea;
    logic [31:0] ed;
    logic es;
    chk("busy", busy, !m_idle);
    chk("done", done, m_done);
    chk("valid_quiet", dump_valid && (m_idle || m_done), 0);
    if (stall_prev) begin
      chk("hold_valid", dump_valid, 1);
      chk("hold_addr", dump_addr, p_addr);
      chk("hold_data", dump_data, p_data);
      chk("hold_last", dump_last, p_last);
      chk("hold_sum", dump_sum, p_sum);
    end
    if (dump_valid && dump_ready && !m_idle && !m_done) begin
      if (n < 32) begin ea = 5'(n); ed = rf[n]; es = 1'b0; end
      else begin ea = 5'h1F; ed = xsum(); es = 1'b1; end
      chk("beat_addr", dump_addr, ea);
      chk("beat_data", dump_data, ed);
      chk("beat_last", dump_last, n == TOTAL - 1);
      chk("beat_sum", dump_sum, es);
      n++;
      fin = n == TOTAL;
    end
    stall_prev = dump_valid && !dump_ready && !RST;
    p_addr = dump_addr; p_data = dump_data; p_last = dump_last; p_sum = dump_sum;
    if (RST) begin m_idle = 1'b1; m_done = 1'b0; n = 0; end
    else if (m_done) begin m_done = 1'b0; m_idle = 1'b1; end
    else if (m_idle) begin if (start) begin m_idle = 1'b0; n = 0; end end
    else if (fin) m_done = 1'b1;
  endtask

  task automatic step();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(string nm);
    int k = 0;
    while (!done && k < 300) begin step(); k++; end
    chk(nm, done, 1);
  endtask

  task automatic wait_beat(string nm, logic [4:0] a);
    int k = 0;
    while (!(dump_valid && dump_addr == a) && k < 300) begin step(); k++; end
    chk(nm, dump_valid && dump_addr == a, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'h4D; rf[3] = 32'h4D; rf[6] = 32'd666;
    @(posedge CLK); #1;
    step(); step();
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aout", A_out, 0);
    chk("rst_addr", dump_addr, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_last", dump_last, 0);
    chk("rst_sum", dump_sum, 0);
    chk("model_xsum", xsum(), 32'h29A);
    RST = 1'b0;
    step();
    // full dump, ready always high
    dump_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("A_read_valid", dump_valid, 0);
    chk("A_read_busy", busy, 1);
    chk("A_read_aout", A_out, 0);
    step();
    chk("A_first_valid", dump_valid, 1);
    chk("A_first_addr", dump_addr, 0);
    wait_beat("A_beat6", 5'd6);
    chk("A_beat6_data", dump_data, 32'h0000029A);
    wait_beat("A_beat31", 5'd31);
    chk("A_beat31_last", dump_last, LAST31);
`ifdef DUMP_CHECKSUM_EN
    begin
      int k = 0;
      while (!(dump_valid && dump_sum) && k < 20) begin step(); k++; end
      chk("B_sum_beat", dump_valid && dump_sum, 1);
      chk("B_sum_data", dump_data, 32'h0000029A);
      chk("B_sum_last", dump_last, 1);
      chk("B_sum_addr", dump_addr, 5'h1F);
    end
`endif
    wait_done("A_done");
    step();
    chk("A_after_done", done, 0);
    chk("A_after_busy", busy, 0);
    // stall on beat 3
    dump_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    begin
      int k = 0;
      while (!(dump_valid && dump_addr == 5'd3) && k < 100) begin
        if (dump_valid) begin dump_ready = 1'b1; step(); dump_ready = 1'b0; end
        else step();
        k++;
      end
    end
    chk("C_at3", dump_valid && dump_addr == 5'd3, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("C_hold_valid", dump_valid, 1);
      chk("C_hold_addr", dump_addr, 5'd3);
      chk("C_hold_data", dump_data, 32'h4D);
    end
    dump_ready = 1'b1;
    step(); step();
    chk("C_next_valid", dump_valid, 1);
    chk("C_next_addr", dump_addr, 5'd4);
    wait_done("C_done");
    step();
    // reset during beat 10
    start = 1'b1;
    step();
    start = 1'b0;
    wait_beat("D_beat10", 5'd10);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("D_valid", dump_valid, 0);
    chk("D_busy", busy, 0);
    chk("D_done", done, 0);
    chk("D_aout", A_out, 0);
    chk("D_addr", dump_addr, 0);
    chk("D_data", dump_data, 0);
    chk("D_last", dump_last, 0);
    chk("D_sum", dump_sum, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("D_restart_valid", dump_valid, 1);
    chk("D_restart_addr", dump_addr, 0);
    wait_done("D_done2");
    step();
    // start held high through a dump
    start = 1'b1;
    step();
    wait_done("E_done");
    step();
    chk("E_idle_busy", busy, 0);
    step();
    chk("E_restart_busy", busy, 1);
    chk("E_restart_aout", A_out, 0);
    start = 1'b0;
    wait_done("E_done2");
    step();
    // start together with reset in IDLE
    RST = 1'b1; start = 1'b1;
    step();
    chk("F_busy", busy, 0);
    RST = 1'b0; start = 1'b0;
    step();
    chk("F_busy2", busy, 0);
    chk("F_valid", dump_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
